// File: rtl/piano_pkg.sv
// ============================================================================
// Module  : piano_pkg
// Brief   : Shared definitions for the piano note recorder and playback:
//           field widths, event-word layout and the playback state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package piano_pkg;

    localparam int NOTE_W = 7;   // one-hot C..B, 0 = rest
    localparam int OCT_W  = 3;

    // Default duration width of an event word, in 256 Hz ticks.
    localparam int EVT_DUR_W = 8;

    // Event word layout: {note, octave, dur}, duration in the low bits.
    localparam int DUR_LSB  = 0;
    localparam int OCT_LSB  = DUR_LSB + EVT_DUR_W;
    localparam int NOTE_LSB = OCT_LSB + OCT_W;

    // Field offsets for an event word with an arbitrary duration width.
    function automatic int oct_lsb(input int dur_w);
        return DUR_LSB + dur_w;
    endfunction

    function automatic int note_lsb(input int dur_w);
        return DUR_LSB + dur_w + OCT_W;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_PLAY  = 2'd3
    } pb_state_e;

endpackage

`default_nettype wire

// File: rtl/note_playback.sv
// ============================================================================
// Module  : note_playback
// Brief   : Reads recorded note events back from the event RAM in order and
//           drives note/octave lines for each event's duration (256 Hz ticks).
//           Optional macro NOTE_PLAYBACK_LOOP_EN: replay the sequence
//           continuously until stop, pulsing done at the end of each pass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module note_playback
    import piano_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DUR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 start,
    input  logic                 stop,
    input  logic [ADDR_W:0]      rec_len,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [10+DUR_W-1:0]  rd_data,
    output logic [NOTE_W-1:0]    note_out,
    output logic [OCT_W-1:0]     octave_out,
    output logic                 playing,
    output logic                 done
);

    localparam int C_OCT_LSB  = oct_lsb(DUR_W);
    localparam int C_NOTE_LSB = note_lsb(DUR_W);

    // Event RAM capacity; longer recordings are clamped to this.
    localparam logic [ADDR_W:0] C_CAP = {1'b1, {ADDR_W{1'b0}}};

    pb_state_e            state_q;
    logic [ADDR_W-1:0]    idx_q;
    logic [ADDR_W:0]      len_q;
    logic [DUR_W-1:0]     dur_q;
    logic [NOTE_W-1:0]    note_q;
    logic [OCT_W-1:0]     oct_q;
    logic                 playing_q;
    logic                 done_q;
    logic                 rd_en_q;
    logic [ADDR_W-1:0]    rd_addr_q;

    logic [ADDR_W:0]      idx_inc_d;
    logic [ADDR_W:0]      len_d;
    logic [DUR_W-1:0]     dur_field_d;

    assign idx_inc_d   = {1'b0, idx_q} + (ADDR_W+1)'(1);
    assign len_d       = (rec_len > C_CAP) ? C_CAP : rec_len;
    assign dur_field_d = rd_data[DUR_LSB +: DUR_W];

    // Playback sequencer: stop beats start, start restarts from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            dur_q     <= '0;
            note_q    <= '0;
            oct_q     <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            if (stop && state_q != ST_IDLE) begin
                state_q   <= ST_IDLE;
                note_q    <= '0;
                oct_q     <= '0;
                playing_q <= 1'b0;
            end else if (start && !stop) begin
                if (rec_len == '0) begin
                    state_q   <= ST_IDLE;
                    note_q    <= '0;
                    oct_q     <= '0;
                    playing_q <= 1'b0;
                    done_q    <= 1'b1;
                end else begin
                    len_q     <= len_d;
                    idx_q     <= '0;
                    rd_addr_q <= '0;
                    rd_en_q   <= 1'b1;
                    playing_q <= 1'b1;
                    state_q   <= ST_FETCH;
                end
            end else begin
                case (state_q)
                    ST_FETCH: begin
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        note_q  <= rd_data[C_NOTE_LSB +: NOTE_W];
                        oct_q   <= rd_data[C_OCT_LSB +: OCT_W];
                        // A zero duration still plays for one tick.
                        dur_q   <= (dur_field_d == '0) ? DUR_W'(1) : dur_field_d;
                        state_q <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (tick) begin
                            if (dur_q == DUR_W'(1)) begin
                                dur_q <= '0;
                                if (idx_inc_d < len_q) begin
                                    idx_q     <= idx_inc_d[ADDR_W-1:0];
                                    rd_addr_q <= idx_inc_d[ADDR_W-1:0];
                                    rd_en_q   <= 1'b1;
                                    state_q   <= ST_FETCH;
                                end else begin
`ifdef NOTE_PLAYBACK_LOOP_EN
                                    done_q    <= 1'b1;
                                    idx_q     <= '0;
                                    rd_addr_q <= '0;
                                    rd_en_q   <= 1'b1;
                                    state_q   <= ST_FETCH;
`else
                                    done_q    <= 1'b1;
                                    note_q    <= '0;
                                    oct_q     <= '0;
                                    playing_q <= 1'b0;
                                    state_q   <= ST_IDLE;
`endif
                                end
                            end else begin
                                dur_q <= dur_q - DUR_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign note_out   = note_q;
    assign octave_out = oct_q;
    assign playing    = playing_q;
    assign done       = done_q;

endmodule

`default_nettype wire

// File: doc/note_playback.md
Name: note_playback

Overview:
- Reader side of the piano's note recording store. The recorder writes note events into a single-port event RAM; this block reads them back in order and replays them.
- For each event it drives the note/octave lines for that event's duration, counted in 256 Hz ticks.
- It sits between the debounced control layer (`toggle_pb` pulse) and the tone generator.
- It is clocked by the system clock; the 256 Hz rate arrives as a single-cycle enable.

Parameters:
- ADDR_W, 6, event RAM address width; capacity is 2^ADDR_W events.
- DUR_W, 8, event duration field width, in 256 Hz ticks.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle enable at 256 Hz.
- start  in  1  single-cycle pulse; begins playback from event 0.
- stop  in  1  single-cycle pulse; aborts playback.
- rec_len  in  ADDR_W+1  number of valid recorded events.
- rd_en  out  1  event RAM read strobe.
- rd_addr  out  ADDR_W  event RAM read address.
- rd_data  in  10+DUR_W  event word {note[6:0], octave[2:0], dur[DUR_W-1:0]}; valid exactly 1 cycle after rd_en.
- note_out  out  7  one-hot note lines (C..B); 0 means rest.
- octave_out  out  3  octave of the current note.
- playing  out  1  high while a sequence is active.
- done  out  1  single-cycle pulse at sequence end or on an empty start.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - All outputs are 0.
  - Index, length and duration registers are 0.
- States: IDLE, FETCH, WAIT, PLAY.
- IDLE:
  - Outputs are 0.
  - `start` with rec_len==0 → `done`=1 on the next cycle; stay in IDLE.
  - `start` with rec_len>0:
    - Latch len = min(rec_len, 2^ADDR_W); later rec_len changes are ignored until the next start.
    - Set idx=0 and go to FETCH.
- FETCH (1 cycle): rd_en=1, rd_addr=idx, playing=1; go to WAIT.
- WAIT (1 cycle):
  - Register note_out and octave_out from rd_data.
  - Load dur_cnt = dur; dur==0 is loaded as 1.
  - Go to PLAY.
  - Note k is therefore visible 3 clocks after the start pulse or after the tick that ends event k-1.
- PLAY: each `tick` decrements dur_cnt. A tick that takes dur_cnt from 1 to 0 does the following:
  - If idx+1 < len: idx++, go to FETCH.
  - Otherwise (last event): next cycle note_out=0, octave_out=0, playing=0, done=1, go to IDLE.
- note_out and octave_out hold the previous event through FETCH/WAIT, so there is no rest glitch between events.
- Rest events (note==0) are timed exactly like notes.
- `stop` in any non-IDLE state → next cycle IDLE; outputs cleared; `done` NOT pulsed.
- `start` while playing → restart from idx 0 via FETCH; `done` NOT pulsed.
- `start` and `stop` in the same cycle → `stop` wins.
- A `tick` during FETCH or WAIT is ignored; durations are measured from PLAY entry.
- rd_en is high only in FETCH.

Optional Feature:
- Macro: NOTE_PLAYBACK_LOOP_EN.
- Defined: at the end of the last event, `done` pulses, idx wraps to 0, the block goes to FETCH, and playing stays 1. Looping continues until `stop`.
- Undefined: the block returns to IDLE at sequence end, as described above.

Decomposition:
- piano_pkg holds:
  - NOTE_W=7 and OCT_W=3.
  - Event word field offsets: NOTE_LSB, OCT_LSB, DUR_LSB.
  - The playback state enum.
- The recorder shares these definitions.
- No sub-module is needed; the duration down-counter is inline.

Test Plan:
1. Reset mid-PLAY (rst_n low for 1 cycle) → all outputs 0 immediately; IDLE; rd_en stays 0 after release.
2. rec_len=0, start → done=1 on the next cycle, playing never rises, rd_en never rises.
3. rec_len=3, events {C,oct4,dur2}, {rest,dur1}, {E,oct5,dur0}:
   - note_out=7'b0000001 from cycle 3 for 2 ticks, then 0 for 1 tick, then 7'b0000100 for 1 tick.
   - Then done=1 and playing=0.
4. stop during event 1 of a 3-event sequence → next cycle note_out=0, playing=0, done stays 0; later start replays from rd_addr=0.
5. start and stop in the same cycle while playing → stop wins; back in IDLE.
6. rec_len=2^ADDR_W+1 (only with ADDR_W chosen so this fits the ADDR_W+1-bit port) → clamped; rd_addr never exceeds 2^ADDR_W-1. With NOTE_PLAYBACK_LOOP_EN, rec_len=2: done pulses after each pass and rd_addr sequence is 0,1,0,1.
